axi_rd_arbiter: RTL

//  Shares the single AXI read-burst path between NREQ cache/uncached requesters (icache, dcache, uncached load).

---
 rtl/axi_rd_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read-burst path between NREQ requesters.
// Define AXI_RD_DPRIO_EN to give requester 0 (dcache) fixed priority over the round-robin group.
module axi_rd_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 32,
  parameter int LW   = 8
) (
  input  logic              clk,
  input  logic              rset,
  input  logic [NREQ-1:0]   s_req,
  input  logic [NREQ*AW-1:0] s_addr,
  input  logic [NREQ*LW-1:0] s_lens,
  input  logic [NREQ-1:0]   s_rready,
  output logic [NREQ-1:0]   s_rvalid,
  output logic [NREQ-1:0]   s_rlast,
  output logic [31:0]       s_rdata,
  output logic [NREQ-1:0]   s_done,
  output logic [NREQ-1:0]   s_grant,
  output logic [AW-1:0]     m_araddr,
  output logic [LW-1:0]     m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  input  logic              m_rlast,
  output logic              m_rready
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [AW-1:0]   araddr_q;
  logic [LW-1:0]   arlen_q;
  logic            arvalid_q;

  logic [NREQ-1:0] rr_req;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   rr_ptr_d;
  logic            in_data;
  int              idx;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
`ifdef AXI_RD_DPRIO_EN
    rr_req  = s_req & {{(NREQ-1){1'b1}}, 1'b0};
`else
    rr_req  = s_req;
`endif
    // first requester at or after rr_ptr, wrapping modulo NREQ
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!win_vld && rr_req[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
`ifdef AXI_RD_DPRIO_EN
    if (s_req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  assign rr_ptr_d = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + IW'(1);

  assign in_data   = (state_q == ST_DATA);
  assign m_rready  = in_data & |(grant_q & s_rready);
  assign s_rvalid  = in_data ? (grant_q & {NREQ{m_rvalid}}) : '0;
  assign s_rlast   = in_data ? (grant_q & {NREQ{m_rlast}})  : '0;
  assign s_rdata   = m_rdata;
  assign s_done    = done_q;
  assign s_grant   = grant_q;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arvalid = arvalid_q;

  always_ff @(posedge clk) begin
    if (!rset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arvalid_q <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          // skip the s_done cycle so the finishing requester can drop s_req first
          if (win_vld && (done_q == '0)) begin
            grant_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            owner_q   <= win_idx;
            araddr_q  <= s_addr[win_idx*AW +: AW];
            arlen_q   <= s_lens[win_idx*LW +: LW];
            arvalid_q <= 1'b1;
            state_q   <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (m_rvalid && m_rready && m_rlast) begin
            done_q  <= grant_q;
            grant_q <= '0;
            state_q <= ST_IDLE;
`ifdef AXI_RD_DPRIO_EN
            if (owner_q != '0) rr_ptr_q <= rr_ptr_d;
`else
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
